trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Interrupt/exception controller for the 5-stage RISC core.
- Latches edge-triggered IRQ lines, arbitrates them by fixed priority, and arbitrates against EX-stage exceptions.
- Drives the intr/excep/flush_ID/flush_EX strobes that the return-PC save logic consumes.
- Captures the saved return PC, redirects fetch to the vector, and sequences mret back to the interrupted code. No nesting.

Parameters:
NUM_IRQ, 8, number of external interrupt lines (1..16)
VEC_BASE, 32'h0000_0100, byte address of vector entry 0
CW, $clog2(NUM_IRQ+1), cause width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
irq_i  in  NUM_IRQ  interrupt lines, rising-edge sensitive, synchronous to i_clk
irq_en_i  in  NUM_IRQ  per-line enable mask
gie_i  in  1  global interrupt enable
excep_req_i  in  1  exception flagged by EX stage (level, valid this cycle)
mret_i  in  1  mret in EX stage this cycle
stall_i  in  1  pipeline hazard stall
pc4save_i  in  32  return PC from save logic
intr_o  out  1  interrupt-taken strobe
excep_o  out  1  exception-taken strobe
flush_ID_o  out  1  flush ID stage
flush_EX_o  out  1  flush EX stage
redirect_o  out  1  fetch-redirect strobe
redirect_pc_o  out  32  redirect target
cause_o  out  CW  cause of active trap: IRQ index, or NUM_IRQ for exception
irq_ack_o  out  NUM_IRQ  one-hot ack pulse of serviced line
in_handler_o  out  1  handler active
epc_o  out  32  captured return PC

Behaviour:
- Reset (async, any state): state=IDLE. pend, irq_q, epc_o and cause_o are 0. All strobes are 0. Any in-flight trap is abandoned and pending IRQs are lost.
- Edge detect: irq_q<=irq_i. pend[i] is set on irq_i[i] & ~irq_q[i] and cleared by irq_ack_o[i]. Set and clear in the same cycle: set wins. Disabled lines stay pending.
- Eligible = pend & irq_en_i, qualified by gie_i. Winner = lowest set index.
- State IDLE:
  - excep_req_i & ~stall_i: excep_o=1, flush_ID_o=flush_EX_o=1, cause<=NUM_IRQ -> FLUSH.
  - Else eligible & ~stall_i: intr_o=1, both flushes=1, cause<=winner -> FLUSH.
  - An exception beats any interrupt in the same cycle. While stall_i=1, entry is deferred with no strobes.
  - mret_i in IDLE is ignored.
- State FLUSH (1 cycle): both flushes=1. The save logic updates pc4save this cycle. stall_i is ignored. -> SAVE.
- State SAVE (1 cycle):
  - epc_o<=pc4save_i.
  - redirect_o=1, redirect_pc_o=VEC_BASE+{cause,2'b00}.
  - irq_ack_o[cause]=1 for interrupts only.
  - -> HANDLER.
- State HANDLER: in_handler_o=1. Interrupts are not taken; they stay pending.
  - excep_req_i: same entry strobes as IDLE, then FLUSH. epc is overwritten (no nesting).
  - mret_i (and no excep_req_i): -> RET.
- State RET (1 cycle): redirect_o=1, redirect_pc_o=epc_o, both flushes=1, in_handler_o=0 -> IDLE.
  - Trap entry is possible no earlier than the cycle after RET.
- Latency: trap request to vector redirect = 2 cycles (strobe cycle, FLUSH, SAVE). mret to redirect = 1 cycle.
- Strobes are Moore outputs of the state, except the IDLE/HANDLER entry strobes, which are combinational from inputs. All strobes are single-cycle except flush (2 cycles on entry).
- redirect_pc_o = 0 whenever redirect_o=0.

Test Plan:
1. Reset mid-SAVE with pend=8'h05 -> next cycle: all outputs 0, state IDLE, pend 0, no irq_ack_o.
2. gie=1, en=8'hFF, rising edges on irq_i[5] and irq_i[2] in the same cycle -> intr_o pulse. After 2 cycles redirect_pc_o=0x108, cause_o=2, irq_ack_o=8'h04. pend[5] remains; it is taken 1 cycle after RET.
3. Same cycle: excep_req_i=1 and eligible irq 0 -> excep_o (not intr_o), cause_o=8, redirect_pc_o=0x120; pend[0] stays set.
4. pc4save_i=0x0000_0040 during SAVE, then mret_i in HANDLER -> epc_o=0x40. Next cycle redirect_o=1, redirect_pc_o=0x40, flushes=1, then IDLE.
5. stall_i=1 for 3 cycles with eligible irq 3 -> no strobes during the stall. intr_o fires the cycle stall_i drops; cause_o=3.
6. irq edge while en=0 -> no trap. Setting en[i]=1 later -> trap taken. Edge on irq_i[1] in the same cycle as irq_ack_o[1] -> pend[1] remains set.

Source files
------------

// File: rtl/trap_sequencer.sv
// Trap sequencer: latches edge-triggered IRQs, arbitrates them against EX-stage
// exceptions, and sequences flush, vector redirect, handler residency and mret return.
module trap_sequencer #(
  parameter int unsigned NUM_IRQ  = 8,
  parameter logic [31:0] VEC_BASE = 32'h0000_0100,
  parameter int unsigned CW       = $clog2(NUM_IRQ + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               gie_i,
  input  logic               excep_req_i,
  input  logic               mret_i,
  input  logic               stall_i,
  input  logic [31:0]        pc4save_i,
  output logic               intr_o,
  output logic               excep_o,
  output logic               flush_ID_o,
  output logic               flush_EX_o,
  output logic               redirect_o,
  output logic [31:0]        redirect_pc_o,
  output logic [CW-1:0]      cause_o,
  output logic [NUM_IRQ-1:0] irq_ack_o,
  output logic               in_handler_o,
  output logic [31:0]        epc_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FLUSH   = 3'd1;
  localparam logic [2:0] ST_SAVE    = 3'd2;
  localparam logic [2:0] ST_HANDLER = 3'd3;
  localparam logic [2:0] ST_RET     = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [CW-1:0]      cause_q, cause_d;
  logic [31:0]        epc_q, epc_d;

  logic [NUM_IRQ-1:0] elig;
  logic [CW-1:0]      winner;
  logic               take_exc;
  logic               take_irq;

  // Fixed-priority arbitration: lowest eligible index wins.
  always_comb begin
    elig   = gie_i ? (pend_q & irq_en_i) : '0;
    winner = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (elig[i]) winner = CW'(i);
    end
    take_exc = excep_req_i & ~stall_i;
    take_irq = (|elig) & ~stall_i;
  end

  // Ack pulses only in SAVE; an exception cause never matches a line index.
  always_comb begin
    irq_ack_o = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      irq_ack_o[i] = (state_q == ST_SAVE) && (cause_q == CW'(i));
    end
  end

  // Pending latch: a new rising edge wins over a same-cycle ack.
  always_comb begin
    irq_d  = irq_i;
    pend_d = (pend_q & ~irq_ack_o) | (irq_i & ~irq_q);
  end

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    intr_o        = 1'b0;
    excep_o       = 1'b0;
    flush_ID_o    = 1'b0;
    flush_EX_o    = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = 32'h0;
    in_handler_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take_exc) begin
          excep_o    = 1'b1;
          flush_ID_o = 1'b1;
          flush_EX_o = 1'b1;
          cause_d    = CW'(NUM_IRQ);
          state_d    = ST_FLUSH;
        end else if (take_irq) begin
          intr_o     = 1'b1;
          flush_ID_o = 1'b1;
          flush_EX_o = 1'b1;
          cause_d    = winner;
          state_d    = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush_ID_o = 1'b1;
        flush_EX_o = 1'b1;
        state_d    = ST_SAVE;
      end
      ST_SAVE: begin
        epc_d         = pc4save_i;
        redirect_o    = 1'b1;
        redirect_pc_o = VEC_BASE + (32'(cause_q) << 2);
        state_d       = ST_HANDLER;
      end
      ST_HANDLER: begin
        in_handler_o = 1'b1;
        if (take_exc) begin
          excep_o    = 1'b1;
          flush_ID_o = 1'b1;
          flush_EX_o = 1'b1;
          cause_d    = CW'(NUM_IRQ);
          state_d    = ST_FLUSH;
        end else if (mret_i && !excep_req_i) begin
          state_d = ST_RET;
        end
      end
      ST_RET: begin
        redirect_o    = 1'b1;
        redirect_pc_o = epc_q;
        flush_ID_o    = 1'b1;
        flush_EX_o    = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      irq_q   <= '0;
      pend_q  <= '0;
      cause_q <= '0;
      epc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  assign cause_o = cause_q;
  assign epc_o   = epc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a per-cycle vector table for the main trap and
// return flows, then hand-written sequences for stall, enable, set-vs-ack and reset.
module tb_trap_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  irq_i, irq_en_i;
  logic        gie_i, excep_req_i, mret_i, stall_i;
  logic [31:0] pc4save_i;
  logic        intr_o, excep_o, flush_ID_o, flush_EX_o, redirect_o, in_handler_o;
  logic [31:0] redirect_pc_o, epc_o;
  logic [3:0]  cause_o;
  logic [7:0]  irq_ack_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  irq;
    logic        exc;
    logic        mret;
    logic [31:0] pc4;
    logic [81:0] expv;
  } vec_t;

  vec_t tbl[$];

  trap_sequencer #(.NUM_IRQ(8), .VEC_BASE(32'h0000_0100)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .irq_i(irq_i), .irq_en_i(irq_en_i),
    .gie_i(gie_i), .excep_req_i(excep_req_i), .mret_i(mret_i), .stall_i(stall_i),
    .pc4save_i(pc4save_i), .intr_o(intr_o), .excep_o(excep_o),
    .flush_ID_o(flush_ID_o), .flush_EX_o(flush_EX_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .cause_o(cause_o), .irq_ack_o(irq_ack_o),
    .in_handler_o(in_handler_o), .epc_o(epc_o)
  );

  always #5 i_clk = ~i_clk;

  // Expected output word: intr, excep, flush_ID, flush_EX, redirect, pc, cause, ack, in_handler, epc.
  function automatic logic [81:0] ev(input logic intr, input logic exc, input logic fl,
                                     input logic red, input logic [31:0] rpc,
                                     input logic [3:0] cause, input logic [7:0] ack,
                                     input logic inh, input logic [31:0] epc);
    return {intr, exc, fl, fl, red, rpc, cause, ack, inh, epc};
  endfunction

  task automatic add(input logic [7:0] irq, input logic exc, input logic mret,
                     input logic [31:0] pc4, input logic [81:0] expv);
    vec_t v;
    v.irq = irq; v.exc = exc; v.mret = mret; v.pc4 = pc4; v.expv = expv;
    tbl.push_back(v);
  endtask

  // Apply one cycle of inputs after the falling edge; outputs settle before the next rise.
  task automatic drive(input logic [7:0] irq, input logic [7:0] en, input logic gie,
                       input logic exc, input logic mret, input logic stall,
                       input logic [31:0] pc4);
    @(negedge i_clk);
    irq_i = irq; irq_en_i = en; gie_i = gie; excep_req_i = exc;
    mret_i = mret; stall_i = stall; pc4save_i = pc4;
    #1;
  endtask

  task automatic chk(input string name, input logic [81:0] expv);
    logic [81:0] act;
    act = {intr_o, excep_o, flush_ID_o, flush_EX_o, redirect_o, redirect_pc_o,
           cause_o, irq_ack_o, in_handler_o, epc_o};
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, expv);
    end
  endtask

  initial begin
    // Main flow: irq5+irq2 together, mret, pend[5] after RET, exception in handler,
    // exception vs irq0 in same cycle, then deferred irq0.
    add(8'h00, 0, 0, 32'h0,   ev(0,0,0,0,32'h0,  4'd0,8'h00,0,32'h0));
    add(8'h24, 0, 0, 32'h0,   ev(0,0,0,0,32'h0,  4'd0,8'h00,0,32'h0));
    add(8'h24, 0, 0, 32'h0,   ev(1,0,1,0,32'h0,  4'd0,8'h00,0,32'h0));
    add(8'h24, 0, 0, 32'h40,  ev(0,0,1,0,32'h0,  4'd2,8'h00,0,32'h0));
    add(8'h00, 0, 0, 32'h40,  ev(0,0,0,1,32'h108,4'd2,8'h04,0,32'h0));
    add(8'h00, 0, 0, 32'h0,   ev(0,0,0,0,32'h0,  4'd2,8'h00,1,32'h40));
    add(8'h00, 0, 1, 32'h0,   ev(0,0,0,0,32'h0,  4'd2,8'h00,1,32'h40));
    add(8'h00, 0, 0, 32'h0,   ev(0,0,1,1,32'h40, 4'd2,8'h00,0,32'h40));
    add(8'h00, 0, 0, 32'h0,   ev(1,0,1,0,32'h0,  4'd2,8'h00,0,32'h40));
    add(8'h00, 0, 0, 32'h0,   ev(0,0,1,0,32'h0,  4'd5,8'h00,0,32'h40));
    add(8'h00, 0, 0, 32'h80,  ev(0,0,0,1,32'h114,4'd5,8'h20,0,32'h40));
    add(8'h00, 1, 0, 32'h0,   ev(0,1,1,0,32'h0,  4'd5,8'h00,1,32'h80));
    add(8'h00, 0, 0, 32'h0,   ev(0,0,1,0,32'h0,  4'd8,8'h00,0,32'h80));
    add(8'h00, 0, 0, 32'hC0,  ev(0,0,0,1,32'h120,4'd8,8'h00,0,32'h80));
    add(8'h00, 0, 1, 32'h0,   ev(0,0,0,0,32'h0,  4'd8,8'h00,1,32'hC0));
    add(8'h00, 0, 0, 32'h0,   ev(0,0,1,1,32'hC0, 4'd8,8'h00,0,32'hC0));
    add(8'h00, 0, 0, 32'h0,   ev(0,0,0,0,32'h0,  4'd8,8'h00,0,32'hC0));
    add(8'h01, 0, 0, 32'h0,   ev(0,0,0,0,32'h0,  4'd8,8'h00,0,32'hC0));
    add(8'h01, 1, 0, 32'h0,   ev(0,1,1,0,32'h0,  4'd8,8'h00,0,32'hC0));
    add(8'h01, 0, 0, 32'h0,   ev(0,0,1,0,32'h0,  4'd8,8'h00,0,32'hC0));
    add(8'h01, 0, 0, 32'h200, ev(0,0,0,1,32'h120,4'd8,8'h00,0,32'hC0));
    add(8'h01, 0, 1, 32'h0,   ev(0,0,0,0,32'h0,  4'd8,8'h00,1,32'h200));
    add(8'h01, 0, 0, 32'h0,   ev(0,0,1,1,32'h200,4'd8,8'h00,0,32'h200));
    add(8'h01, 0, 0, 32'h0,   ev(1,0,1,0,32'h0,  4'd8,8'h00,0,32'h200));
    add(8'h01, 0, 0, 32'h0,   ev(0,0,1,0,32'h0,  4'd0,8'h00,0,32'h200));
    add(8'h01, 0, 0, 32'h300, ev(0,0,0,1,32'h100,4'd0,8'h01,0,32'h200));
    add(8'h01, 0, 1, 32'h0,   ev(0,0,0,0,32'h0,  4'd0,8'h00,1,32'h300));
    add(8'h00, 0, 0, 32'h0,   ev(0,0,1,1,32'h300,4'd0,8'h00,0,32'h300));
    add(8'h00, 0, 0, 32'h0,   ev(0,0,0,0,32'h0,  4'd0,8'h00,0,32'h300));

    i_rst_n = 1'b0;
    irq_i = '0; irq_en_i = 8'hFF; gie_i = 1'b1; excep_req_i = 1'b0;
    mret_i = 1'b0; stall_i = 1'b0; pc4save_i = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_state", ev(0,0,0,0,32'h0,4'd0,8'h00,0,32'h0));
    i_rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].irq, 8'hFF, 1'b1, tbl[i].exc, tbl[i].mret, 1'b0, tbl[i].pc4);
      chk($sformatf("vec%0d", i), tbl[i].expv);
    end

    // Stall defers entry on eligible irq3; FLUSH ignores stall; mret in IDLE ignored.
    drive(8'h08, 8'hFF, 1, 0, 0, 0, 32'h0); chk("st_edge", ev(0,0,0,0,32'h0,4'd0,8'h00,0,32'h300));
    for (int k = 0; k < 3; k++) begin
      drive(8'h08, 8'hFF, 1, 0, 0, 1, 32'h0);
      chk($sformatf("st_hold%0d", k), ev(0,0,0,0,32'h0,4'd0,8'h00,0,32'h300));
    end
    drive(8'h08, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("st_take",  ev(1,0,1,0,32'h0,  4'd0,8'h00,0,32'h300));
    drive(8'h00, 8'hFF, 1, 0, 0, 1, 32'h0);   chk("st_flush", ev(0,0,1,0,32'h0,  4'd3,8'h00,0,32'h300));
    drive(8'h00, 8'hFF, 1, 0, 0, 0, 32'h400); chk("st_save",  ev(0,0,0,1,32'h10C,4'd3,8'h08,0,32'h300));
    drive(8'h00, 8'hFF, 1, 0, 1, 0, 32'h0);   chk("st_hand",  ev(0,0,0,0,32'h0,  4'd3,8'h00,1,32'h400));
    drive(8'h00, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("st_ret",   ev(0,0,1,1,32'h400,4'd3,8'h00,0,32'h400));
    drive(8'h00, 8'hFF, 1, 0, 1, 0, 32'h0);   chk("mret_idle",ev(0,0,0,0,32'h0,  4'd3,8'h00,0,32'h400));
    drive(8'h00, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("mret_idle2",ev(0,0,0,0,32'h0, 4'd3,8'h00,0,32'h400));

    // Disabled line stays pending; new edge coincident with its ack keeps it pending.
    drive(8'h02, 8'h00, 1, 0, 0, 0, 32'h0);   chk("en_edge",  ev(0,0,0,0,32'h0,  4'd3,8'h00,0,32'h400));
    drive(8'h02, 8'h00, 1, 0, 0, 0, 32'h0);   chk("en_off0",  ev(0,0,0,0,32'h0,  4'd3,8'h00,0,32'h400));
    drive(8'h02, 8'h00, 1, 0, 0, 0, 32'h0);   chk("en_off1",  ev(0,0,0,0,32'h0,  4'd3,8'h00,0,32'h400));
    drive(8'h00, 8'h02, 1, 0, 0, 0, 32'h0);   chk("en_on",    ev(1,0,1,0,32'h0,  4'd3,8'h00,0,32'h400));
    drive(8'h00, 8'h02, 1, 0, 0, 0, 32'h0);   chk("en_flush", ev(0,0,1,0,32'h0,  4'd1,8'h00,0,32'h400));
    drive(8'h02, 8'h02, 1, 0, 0, 0, 32'h500); chk("ack_edge", ev(0,0,0,1,32'h104,4'd1,8'h02,0,32'h400));
    drive(8'h02, 8'h02, 1, 0, 1, 0, 32'h0);   chk("ae_hand",  ev(0,0,0,0,32'h0,  4'd1,8'h00,1,32'h500));
    drive(8'h02, 8'h02, 1, 0, 0, 0, 32'h0);   chk("ae_ret",   ev(0,0,1,1,32'h500,4'd1,8'h00,0,32'h500));
    drive(8'h02, 8'h02, 1, 0, 0, 0, 32'h0);   chk("ae_retake",ev(1,0,1,0,32'h0,  4'd1,8'h00,0,32'h500));
    drive(8'h00, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("ae_flush", ev(0,0,1,0,32'h0,  4'd1,8'h00,0,32'h500));
    drive(8'h00, 8'hFF, 1, 0, 0, 0, 32'h600); chk("ae_save",  ev(0,0,0,1,32'h104,4'd1,8'h02,0,32'h500));
    drive(8'h00, 8'hFF, 1, 0, 1, 0, 32'h0);   chk("ae_hand2", ev(0,0,0,0,32'h0,  4'd1,8'h00,1,32'h600));
    drive(8'h00, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("ae_ret2",  ev(0,0,1,1,32'h600,4'd1,8'h00,0,32'h600));

    // Reset asserted mid-SAVE with pend=0x05: everything cleared, pending lost.
    drive(8'h05, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("rs_edge",  ev(0,0,0,0,32'h0,  4'd1,8'h00,0,32'h600));
    drive(8'h05, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("rs_take",  ev(1,0,1,0,32'h0,  4'd1,8'h00,0,32'h600));
    drive(8'h05, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("rs_flush", ev(0,0,1,0,32'h0,  4'd0,8'h00,0,32'h600));
    drive(8'h05, 8'hFF, 1, 0, 0, 0, 32'h700); chk("rs_save",  ev(0,0,0,1,32'h100,4'd0,8'h01,0,32'h600));
    #1;
    i_rst_n = 1'b0;
    irq_i = 8'h00;
    #1;
    chk("rs_async", ev(0,0,0,0,32'h0,4'd0,8'h00,0,32'h0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(8'h00, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("rs_after0",ev(0,0,0,0,32'h0,  4'd0,8'h00,0,32'h0));
    drive(8'h00, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("rs_after1",ev(0,0,0,0,32'h0,  4'd0,8'h00,0,32'h0));

    // Global enable gates entry; line stays pending until gie rises.
    drive(8'h10, 8'hFF, 0, 0, 0, 0, 32'h0);   chk("gie_edge", ev(0,0,0,0,32'h0,  4'd0,8'h00,0,32'h0));
    drive(8'h10, 8'hFF, 0, 0, 0, 0, 32'h0);   chk("gie_off",  ev(0,0,0,0,32'h0,  4'd0,8'h00,0,32'h0));
    drive(8'h10, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("gie_on",   ev(1,0,1,0,32'h0,  4'd0,8'h00,0,32'h0));
    drive(8'h10, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("gie_flush",ev(0,0,1,0,32'h0,  4'd4,8'h00,0,32'h0));
    drive(8'h10, 8'hFF, 1, 0, 0, 0, 32'h0);   chk("gie_save", ev(0,0,0,1,32'h110,4'd4,8'h10,0,32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
